// File: rtl/mem_store_buf_pkg.sv
// Shared constants and types for the committed-store buffer and its
// store formatter.
package mem_store_buf_pkg;

   localparam logic        RSTN_ENABLE = 1'b0;
   localparam logic        TRUE_V      = 1'b1;
   localparam logic        FALSE_V     = 1'b0;
   localparam logic [31:0] ZERO_32     = 32'h0000_0000;

   localparam logic [1:0]  SIZE_BYTE   = 2'd0;
   localparam logic [1:0]  SIZE_HALF   = 2'd1;
   localparam logic [1:0]  SIZE_WORD   = 2'd2;

   localparam int          STRB_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT
   } drainState_t;

   typedef struct packed {
      logic [31:0]       addr;
      logic [STRB_W-1:0] wstrb;
      logic [31:0]       wdata;
      logic [1:0]        size;
   } storeEntry_t;

endpackage

// File: rtl/mem_store_buf_store_fmt.sv
// Turns a right-aligned store into byte strobes plus lane-replicated data.
// Shared with the uncached store path.
module mem_store_buf_store_fmt
   import mem_store_buf_pkg::*;
(
   input  logic [1:0]        addr_i,
   input  logic [1:0]        size_i,
   input  logic [31:0]       wdata_i,
   output logic [STRB_W-1:0] wstrb_o,
   output logic [31:0]       wdataRep_o
);

   // Reserved size 3 falls through to the word encoding.
   always_comb begin
      wstrb_o    = '0;
      wdataRep_o = ZERO_32;
      case (size_i)
         SIZE_BYTE: begin
            wstrb_o    = 4'b0001 << addr_i;
            wdataRep_o = {4{wdata_i[7:0]}};
         end
         SIZE_HALF: begin
            wstrb_o    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdataRep_o = {2{wdata_i[15:0]}};
         end
         SIZE_WORD: begin
            wstrb_o    = 4'b1111;
            wdataRep_o = wdata_i;
         end
         default: begin
            wstrb_o    = 4'b1111;
            wdataRep_o = wdata_i;
         end
      endcase
   end

endmodule

// File: rtl/mem_store_buf.sv
// Committed-store FIFO that drains one write at a time over an addr_ok/data_ok
// bus and flags loads that alias a still-pending store.
module mem_store_buf
   import mem_store_buf_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        st_valid,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_wdata,
   input  logic [1:0]  st_size,
   output logic        st_ready,
   output logic        buf_stall,
   input  logic [31:0] ld_addr,
   output logic        ld_hit,
   output logic        buf_empty,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [3:0]  data_wstrb,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok
);

   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] ONE_COUNT  = (PTR_W+1)'(1);

   storeEntry_t       entry_q [DEPTH];
   storeEntry_t       head;
   logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
   logic [PTR_W:0]    count_q, count_d;
   drainState_t       state_q;
   logic              dataReq_q;
   logic              push, pop;
   logic [STRB_W-1:0] fmtStrb;
   logic [31:0]       fmtData;
   logic [PTR_W-1:0]  slot;
   logic              ldHit;
   logic              unusedLdBits;

   mem_store_buf_store_fmt storeFmt (
      .addr_i     (st_addr[1:0]),
      .size_i     (st_size),
      .wdata_i    (st_wdata),
      .wstrb_o    (fmtStrb),
      .wdataRep_o (fmtData)
   );

   // Readiness uses the pre-edge count, so a pop never frees a slot in the same cycle.
   assign st_ready  = (count_q != FULL_COUNT);
   assign buf_stall = st_valid & ~st_ready;
   assign push      = st_valid & st_ready;
   assign pop       = (state_q == ST_WAIT) & data_data_ok;

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (push) wrPtr_d = wrPtr_q + 1'b1;
      if (pop)  rdPtr_d = rdPtr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         entry_q[wrPtr_q] <= '{addr: st_addr, wstrb: fmtStrb, wdata: fmtData, size: st_size};
      end
   end

   always_ff @(posedge clk) begin
      if (resetn == RSTN_ENABLE) begin
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         count_q   <= '0;
         state_q   <= ST_IDLE;
         dataReq_q <= FALSE_V;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
         case (state_q)
            ST_IDLE: begin
               if (count_q != '0) begin
                  state_q   <= ST_REQ;
                  dataReq_q <= TRUE_V;
               end
            end
            ST_REQ: begin
               if (data_addr_ok) begin
                  state_q   <= ST_WAIT;
                  dataReq_q <= FALSE_V;
               end
            end
            ST_WAIT: begin
               if (data_data_ok) begin
                  if (count_q > ONE_COUNT) begin
                     state_q   <= ST_REQ;
                     dataReq_q <= TRUE_V;
                  end else begin
                     state_q   <= ST_IDLE;
                     dataReq_q <= FALSE_V;
                  end
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               dataReq_q <= FALSE_V;
            end
         endcase
      end
   end

   // Only slots between the read pointer and count are live; the head stays live until popped.
   always_comb begin
      ldHit = 1'b0;
      slot  = rdPtr_q;
      for (int k = 0; k < DEPTH; k++) begin
         slot = rdPtr_q + PTR_W'(k);
         if (((PTR_W+1)'(k) < count_q) && (entry_q[slot].addr[31:2] == ld_addr[31:2])) begin
            ldHit = 1'b1;
         end
      end
   end

   assign unusedLdBits = ^ld_addr[1:0];
   assign ld_hit       = ldHit;

   assign head       = entry_q[rdPtr_q];
   assign data_req   = dataReq_q;
   assign data_wr    = TRUE_V;
   assign data_size  = head.size;
   assign data_addr  = head.addr;
   assign data_wstrb = head.wstrb;
   assign data_wdata = head.wdata;
   assign buf_empty  = (count_q == '0) & (state_q == ST_IDLE);

endmodule

// File: tb/tb_mem_store_buf.sv
// Directed scoreboard bench for mem_store_buf: stimulus queues expected bus
// writes, a monitor pops and compares them at every accepted request.
module tb_mem_store_buf;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] data;
      logic [1:0]  size;
   } expWrite_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
      logic [3:0]  strb;
      logic [31:0] rep;
   } vector_t;

   logic        clk;
   logic        resetn;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_wdata;
   logic [1:0]  st_size;
   logic        st_ready;
   logic        buf_stall;
   logic [31:0] ld_addr;
   logic        ld_hit;
   logic        buf_empty;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;

   expWrite_t   expQ[$];
   int          checkCount = 0;
   int          passCount  = 0;
   logic        busAuto    = 1'b0;

   mem_store_buf #(.DEPTH(4), .PTR_W(2)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .st_valid     (st_valid),
      .st_addr      (st_addr),
      .st_wdata     (st_wdata),
      .st_size      (st_size),
      .st_ready     (st_ready),
      .buf_stall    (buf_stall),
      .ld_addr      (ld_addr),
      .ld_hit       (ld_hit),
      .buf_empty    (buf_empty),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wstrb   (data_wstrb),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   task automatic reportTimeout(input string name);
      checkCount++;
      $display("[TB] FAIL %s: got timeout, expected event", name);
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      st_valid = 1'b1;
      st_addr  = a;
      st_wdata = d;
      st_size  = s;
   endtask

   // Holds the applied store until it is accepted, then records the expected write.
   task automatic finishStore(input logic [3:0] strb, input logic [31:0] rep);
      int waited = 0;
      while (st_ready !== 1'b1 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (st_ready !== 1'b1) begin
         reportTimeout("storeAccept");
         st_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         st_valid = 1'b0;
         expQ.push_back('{addr: st_addr, strb: strb, data: rep, size: st_size});
      end
   endtask

   task automatic pushStore(input vector_t v);
      applyStimulus(v.addr, v.data, v.size);
      @(negedge clk);
      finishStore(v.strb, v.rep);
   endtask

   task automatic waitIdle(input string name, input int budget);
      int n = 0;
      while (buf_empty !== 1'b1 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput(name, 80'(buf_empty), 80'(1'b1));
   endtask

   task automatic waitReq(input string name);
      int n = 0;
      @(negedge clk);
      while (data_req !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (data_req !== 1'b1) reportTimeout(name);
   endtask

   // Automatic bus: accept a request, then complete it two cycles later.
   initial begin
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      forever begin
         @(negedge clk);
         if (busAuto && data_req === 1'b1 && resetn === 1'b1) begin
            data_addr_ok = 1'b1;
            @(negedge clk);
            data_addr_ok = 1'b0;
            @(negedge clk);
            data_data_ok = 1'b1;
            @(negedge clk);
            data_data_ok = 1'b0;
         end
      end
   end

   initial begin
      expWrite_t e;
      forever begin
         @(negedge clk);
         #2;
         if (resetn === 1'b1 && data_req === 1'b1 && data_addr_ok === 1'b1) begin
            if (expQ.size() == 0) begin
               checkCount++;
               $display("[TB] FAIL unexpectedWrite: got addr %0h, expected no write", data_addr);
            end else begin
               e = expQ.pop_front();
               checkOutput("busWrite",
                  80'({data_wr, data_addr, data_wstrb, data_wdata, data_size}),
                  80'({1'b1, e.addr, e.strb, e.data, e.size}));
            end
         end
      end
   end

   initial begin
      vector_t fillVec[5];
      vector_t wrapVec[12];
      vector_t v;

      fillVec[0] = '{32'h0000_0000, 32'hA000_0000, 2'd2, 4'b1111, 32'hA000_0000};
      fillVec[1] = '{32'h0000_0004, 32'hA000_0001, 2'd2, 4'b1111, 32'hA000_0001};
      fillVec[2] = '{32'h0000_0008, 32'hA000_0002, 2'd2, 4'b1111, 32'hA000_0002};
      fillVec[3] = '{32'h0000_000C, 32'hA000_0003, 2'd2, 4'b1111, 32'hA000_0003};
      fillVec[4] = '{32'h0000_0010, 32'hA000_0004, 2'd2, 4'b1111, 32'hA000_0004};

      wrapVec[0]  = '{32'h0000_4000, 32'h0000_0011, 2'd0, 4'b0001, 32'h1111_1111};
      wrapVec[1]  = '{32'h0000_4005, 32'h0000_0022, 2'd0, 4'b0010, 32'h2222_2222};
      wrapVec[2]  = '{32'h0000_400A, 32'h0000_0033, 2'd0, 4'b0100, 32'h3333_3333};
      wrapVec[3]  = '{32'h0000_400F, 32'h0000_0044, 2'd0, 4'b1000, 32'h4444_4444};
      wrapVec[4]  = '{32'h0000_4010, 32'h0000_BEEF, 2'd1, 4'b0011, 32'hBEEF_BEEF};
      wrapVec[5]  = '{32'h0000_4016, 32'h0000_CAFE, 2'd1, 4'b1100, 32'hCAFE_CAFE};
      wrapVec[6]  = '{32'h0000_4018, 32'hDEAD_BEEF, 2'd2, 4'b1111, 32'hDEAD_BEEF};
      wrapVec[7]  = '{32'h0000_401C, 32'h1234_5678, 2'd3, 4'b1111, 32'h1234_5678};
      wrapVec[8]  = '{32'h0000_4021, 32'hFFFF_FF5A, 2'd0, 4'b0010, 32'h5A5A_5A5A};
      wrapVec[9]  = '{32'h0000_4022, 32'hABCD_0F0F, 2'd1, 4'b1100, 32'h0F0F_0F0F};
      wrapVec[10] = '{32'h0000_4024, 32'h0000_0001, 2'd2, 4'b1111, 32'h0000_0001};
      wrapVec[11] = '{32'h0000_4027, 32'h0000_0080, 2'd0, 4'b1000, 32'h8080_8080};

      resetn   = 1'b0;
      st_valid = 1'b0;
      st_addr  = '0;
      st_wdata = '0;
      st_size  = '0;
      ld_addr  = '0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("resetReady", 80'(st_ready), 80'(1'b1));
      checkOutput("resetStall", 80'(buf_stall), 80'(1'b0));
      checkOutput("resetReq", 80'(data_req), 80'(1'b0));
      checkOutput("resetEmpty", 80'(buf_empty), 80'(1'b1));
      checkOutput("resetHit", 80'(ld_hit), 80'(1'b0));
      resetn = 1'b1;

      // Single byte store and its request latency.
      busAuto = 1'b1;
      applyStimulus(32'h1000_0003, 32'h0000_00A5, 2'd0);
      @(posedge clk);
      #1;
      st_valid = 1'b0;
      expQ.push_back('{addr: 32'h1000_0003, strb: 4'b1000, data: 32'hA5A5_A5A5, size: 2'd0});
      checkOutput("reqAfterE0", 80'(data_req), 80'(1'b0));
      checkOutput("emptyAfterPush", 80'(buf_empty), 80'(1'b0));
      @(posedge clk);
      #1;
      checkOutput("reqAfterE1", 80'(data_req), 80'(1'b1));
      waitIdle("byteDrained", 100);

      // Fill with the bus stalled, then release.
      busAuto = 1'b0;
      for (int i = 0; i < 4; i++) pushStore(fillVec[i]);
      applyStimulus(fillVec[4].addr, fillVec[4].data, fillVec[4].size);
      @(negedge clk);
      checkOutput("fullReady", 80'(st_ready), 80'(1'b0));
      checkOutput("fullStall", 80'(buf_stall), 80'(1'b1));
      ld_addr = 32'h0000_000E;
      #1;
      checkOutput("fullAliasHit", 80'(ld_hit), 80'(1'b1));
      busAuto = 1'b1;
      finishStore(fillVec[4].strb, fillVec[4].rep);
      waitIdle("fillDrained", 300);

      // Load alias against a pending half store.
      busAuto = 1'b0;
      v = '{32'h0000_2002, 32'h0000_1234, 2'd1, 4'b1100, 32'h1234_1234};
      pushStore(v);
      ld_addr = 32'h0000_2000;
      #1;
      checkOutput("aliasHit", 80'(ld_hit), 80'(1'b1));
      ld_addr = 32'h0000_2004;
      #1;
      checkOutput("aliasMissNextWord", 80'(ld_hit), 80'(1'b0));
      ld_addr = 32'h0000_2000;
      waitReq("aliasReq");
      data_addr_ok = 1'b1;
      @(negedge clk);
      data_addr_ok = 1'b0;
      checkOutput("aliasHitInWait", 80'(ld_hit), 80'(1'b1));
      @(negedge clk);
      data_data_ok = 1'b1;
      @(negedge clk);
      data_data_ok = 1'b0;
      checkOutput("aliasClearedAfterPop", 80'(ld_hit), 80'(1'b0));
      checkOutput("aliasEmpty", 80'(buf_empty), 80'(1'b1));

      // Reset while a write is outstanding with three entries held.
      pushStore('{32'h0000_3000, 32'h0000_3000, 2'd2, 4'b1111, 32'h0000_3000});
      pushStore('{32'h0000_3004, 32'h0000_3004, 2'd2, 4'b1111, 32'h0000_3004});
      pushStore('{32'h0000_3008, 32'h0000_3008, 2'd2, 4'b1111, 32'h0000_3008});
      waitReq("resetTestReq");
      data_addr_ok = 1'b1;
      @(negedge clk);
      data_addr_ok = 1'b0;
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      expQ.delete();
      checkOutput("midResetReq", 80'(data_req), 80'(1'b0));
      checkOutput("midResetEmpty", 80'(buf_empty), 80'(1'b1));
      checkOutput("midResetReady", 80'(st_ready), 80'(1'b1));
      @(negedge clk);
      data_data_ok = 1'b1;
      @(negedge clk);
      data_data_ok = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("strayOkReq", 80'(data_req), 80'(1'b0));
      checkOutput("strayOkEmpty", 80'(buf_empty), 80'(1'b1));
      checkOutput("strayOkHit", 80'(ld_hit), 80'(1'b0));
      busAuto = 1'b1;
      pushStore('{32'h0000_3100, 32'h5555_AAAA, 2'd2, 4'b1111, 32'h5555_AAAA});
      waitIdle("postResetDrained", 100);

      // Streaming stores: overlapping push/pop and pointer wrap.
      for (int i = 0; i < 12; i++) pushStore(wrapVec[i]);
      waitIdle("wrapDrained", 500);

      repeat (4) @(posedge clk);
      #1;
      checkOutput("scoreboardDrained", 80'(expQ.size()), 80'(0));

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/mem_store_buf.md
Name: mem_store_buf

Overview:
Write-side companion to the load-data capture path. It accepts committed stores from the MEM stage into a small FIFO and formats each one into a byte-strobed word write. It drains the FIFO to the data SRAM-like bus using an addr_ok/data_ok handshake with one outstanding write. It also flags loads that alias a pending store, so the pipeline can stall the load until the store has drained.

Parameters:
DEPTH, 4, number of store entries; power of two, at least 2
PTR_W, 2, log2(DEPTH)

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  synchronous reset, active-low (`rstn_enable = 0)
st_valid  in  1  MEM stage presents a committed store this cycle
st_addr  in  32  store byte address
st_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
st_size  in  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word
st_ready  out  1  buffer can accept a store (not full)
buf_stall  out  1  st_valid & ~st_ready; feeds the stall controller
ld_addr  in  32  byte address of the load currently in MEM
ld_hit  out  1  a pending entry has the same word address as ld_addr
buf_empty  out  1  no entries and no write in flight
data_req  out  1  write request valid
data_wr  out  1  constant 1
data_size  out  2  size of the head entry
data_addr  out  32  address of the head entry
data_wstrb  out  4  byte strobes of the head entry
data_wdata  out  32  lane-replicated data of the head entry
data_addr_ok  in  1  bus accepted the address/request
data_data_ok  in  1  bus completed the write

Behaviour:
- Reset (resetn = 0 at a rising edge):
  - wptr, rptr and count are cleared; state goes to IDLE.
  - Outputs after that edge: st_ready = 1, buf_stall = 0, ld_hit = 0, buf_empty = 1, data_req = 0.
  - Reset mid-transaction abandons the in-flight write; the bus is reset by the same resetn.
- Push: at a rising edge where st_valid & st_ready, the entry {addr, formatted wstrb, replicated wdata, size} is written at wptr, and wptr increments mod DEPTH.
- Full: when count == DEPTH, st_ready = 0 and the push is ignored. buf_stall asserts combinationally.
- No flush input. Entries are committed and are never discarded except by reset.
- Formatting (combinational, at entry):
  - byte: wstrb = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - half: wstrb = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - word: wstrb = 4'b1111; wdata unchanged.
  - Misalignment is trapped upstream and not checked here.
- Drain FSM (state is registered; data_* are driven from the head entry):
  - IDLE: data_req = 0. If count != 0, go to REQ.
  - REQ: data_req = 1 and the head fields are held stable. On data_addr_ok, go to WAIT.
  - WAIT: data_req = 0. On data_data_ok, pop the head (rptr++), then go to REQ if count > 1, else IDLE.
  - data_data_ok is never asserted in the same cycle as its own addr_ok. A data_ok seen outside WAIT is ignored.
- Latency: a store pushed at edge E0 reaches REQ at edge E1, so data_req is high in the cycle after E1. Back-to-back entries: REQ is re-entered directly at the data_ok edge.
- Simultaneous push and pop: count is unchanged, both pointers advance. A push into a full buffer in the pop cycle is still refused, because st_ready is based on the pre-edge count.
- ld_hit is combinational: OR over all occupied entries (head included until popped) of entry.addr[31:2] == ld_addr[31:2].
- Pointer wrap: pointers wrap mod DEPTH; occupancy is tracked by count (0..DEPTH, PTR_W+1 bits).
- buf_empty = (count == 0) & (state == IDLE).

Decomposition:
- defines_cpu.vh holds: `rstn_enable, `true_v/`false_v, `zero_32, the size encodings (`size_byte/`size_half/`size_word), and the strobe width.
- One sub-module, store_fmt: purely combinational (addr[1:0], size, wdata) -> (wstrb, wdata_rep), reused by the uncached store path.
- The FIFO and FSM stay in mem_store_buf.

Test Plan:
- Reset with no activity: resetn = 0 for 2 cycles -> st_ready = 1, data_req = 0, buf_empty = 1, ld_hit = 0.
- Single byte store: addr 0x1000_0003, wdata 0x0000_00A5, size 0 -> data_req in the cycle after E1 with wstrb = 4'b1000, wdata = 0xA5A5_A5A5; addr_ok one cycle later, data_ok two cycles after that -> buf_empty = 1.
- Fill: 5 word stores with addr_ok tied low -> st_ready = 0 and buf_stall = 1 on the 5th. Then release addr_ok/data_ok -> 4 writes issue in push order 0x0, 0x4, 0x8, 0xC. The 5th is accepted once the first pop occurs.
- Simultaneous push/pop at count = 2 -> count stays 2; the pointers wrap past DEPTH-1 without loss. Data order is verified against a scoreboard over 20 random stores.
- Load alias: pending half store at 0x2002 with ld_addr = 0x2000 -> ld_hit = 1. ld_addr = 0x2004 -> ld_hit = 0. After data_ok pops the entry -> ld_hit = 0.
- Reset in WAIT with 3 entries -> next cycle: count = 0, data_req = 0; a stray data_ok afterwards changes nothing.
